object_ram_arbiter: RTL and testbench
=====================================

Name: object_ram_arbiter

Overview:
- Shares the single-port 16-entry x 32-bit object (stone) RAM among three requesters: the draw engine (read-only) and two rope controllers (read/write; rope1 is used only in two-player mode).
- Serialises all accesses and returns read data with a valid strobe.
- Provides a per-rope lock so a rope can read-modify-write an object (claim, move, hide) without the other rope interleaving.
- Sits between the rope controllers, the draw engine and the RAM instance.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 32, RAM word width.
- RD_LAT, 2, cycles from ram_addr presented to ram_q valid (range 1-3).
- LOCK_TIMEOUT, 4096, maximum cycles a lock may be held before forced release.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- draw_req  in  1  draw engine read request.
- draw_addr  in  ADDR_W  draw read address.
- draw_gnt  out  1  one-cycle pulse: draw request accepted.
- draw_rvalid  out  1  one-cycle pulse: draw_rdata valid.
- draw_rdata  out  DATA_W  draw read data.
- rope0_req  in  1  rope0 access request.
- rope0_we  in  1  1 = write, 0 = read.
- rope0_lock  in  1  request or hold the exclusive rope lock.
- rope0_addr  in  ADDR_W  address.
- rope0_wdata  in  DATA_W  write data.
- rope0_gnt  out  1  one-cycle accept pulse.
- rope0_rvalid  out  1  read data valid pulse.
- rope0_rdata  out  DATA_W  read data.
- rope1_*: identical set to rope0_*.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM read data.
- lock_owner  out  2  00 none, 01 rope0, 10 rope1.
- lock_timeout_err  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset values: all gnt, rvalid, ram_wren and lock_timeout_err = 0; all rdata = 0; ram_addr = 0; ram_wdata = 0; lock_owner = 00; round-robin pointer = rope0; FSM = S_IDLE.
- Reset mid-transaction aborts it:
  - no rvalid is issued afterwards;
  - a write already pulsed on ram_wren is not undone.
- Requesters hold req, we, addr and wdata stable until gnt. Deasserting req before gnt withdraws the request.
- FSM states:
  - S_IDLE: arbitrate among asserted requests.
    - Priority: draw > lock owner > other rope (only if no lock is held) > round robin between ropes when unlocked.
    - Round robin: pointer moves to the non-granted rope after each rope grant.
    - On a winner, in the same cycle: assert gnt, drive ram_addr; for a write also drive ram_wdata with ram_wren = 1.
    - Next state: S_WRITE_DONE for a write, S_READ_WAIT for a read.
  - S_READ_WAIT: count RD_LAT cycles. On the cycle ram_q is valid, register it into the winner's rdata. rvalid pulses on the following cycle. Then go to S_IDLE.
  - S_WRITE_DONE: one turnaround cycle, then S_IDLE.
- Latencies:
  - Read: gnt at cycle T, rvalid at T+RD_LAT+1.
  - Write: gnt and ram_wren at T; next grant no earlier than T+2.
- rdata holds its value until that requester's next read completes.
- Lock rules:
  - Acquire: a rope granted with lock = 1 while lock_owner = 00 becomes owner at the grant cycle.
  - Release: a grant to the owner with lock = 0, or the owner's lock dropping while it has no request pending.
  - While locked, the non-owner rope is never granted. The draw engine is still served (read-only, so no hazard).
- Lock timeout:
  - A counter is cleared at acquire and at each owner grant.
  - When it reaches LOCK_TIMEOUT, the lock is force-released and lock_timeout_err pulses for one cycle.
  - The pointer is then set to the non-owner rope.
- Simultaneous events:
  - draw_req with a rope request: draw wins; the rope waits.
  - Both ropes requesting with lock = 1 and no owner: the round-robin pointer decides; the loser stays pending.
- One transaction is in flight at a time; no pipelining.
- Address and data are muxed from the registered winner, not from live inputs after the grant cycle.

Test Plan:
- RD_LAT=2, preload addr 3 = 0x12345678; rope0 read addr 3 -> rope0_gnt at T, rope0_rvalid at T+3 with rdata 0x12345678; other strobes stay 0.
- rope0 write addr 5 data 0xA5A5A5A5, then draw read addr 5 -> ram_wren is one cycle only; draw_rdata = 0xA5A5A5A5.
- draw_req, rope0_req and rope1_req asserted in the same cycle, held -> grant order draw, rope0, rope1, with draw re-granted between ropes while draw_req stays high.
- rope0 locked read addr 2, rope1 requests write addr 2 -> rope1 not granted until rope0 writes with lock = 0; lock_owner goes 01 -> 00; rope1 gnt follows.
- LOCK_TIMEOUT=16, rope0 acquires lock then idles with lock held -> after 16 cycles lock_timeout_err pulses once, lock_owner = 00, pending rope1 granted next.
- Assert reset during S_READ_WAIT -> no rvalid afterwards; all outputs return to reset values the following cycle.

Source files
------------

// File: rtl/object_ram_arbiter.sv
// Object RAM arbiter: shares the single-port stone RAM between the draw engine
// and two rope controllers, with an exclusive per-rope lock for read-modify-write.
module object_ram_arbiter #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata,
  input  logic              rope0_req,
  input  logic              rope0_we,
  input  logic              rope0_lock,
  input  logic [ADDR_W-1:0] rope0_addr,
  input  logic [DATA_W-1:0] rope0_wdata,
  output logic              rope0_gnt,
  output logic              rope0_rvalid,
  output logic [DATA_W-1:0] rope0_rdata,
  input  logic              rope1_req,
  input  logic              rope1_we,
  input  logic              rope1_lock,
  input  logic [ADDR_W-1:0] rope1_addr,
  input  logic [DATA_W-1:0] rope1_wdata,
  output logic              rope1_gnt,
  output logic              rope1_rvalid,
  output logic [DATA_W-1:0] rope1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [1:0]        lock_owner,
  output logic              lock_timeout_err
);

  localparam int unsigned RD_CNT_W   = 2;
  localparam int unsigned LOCK_CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [1:0]  OWN_NONE   = 2'b00;
  localparam logic [1:0]  OWN_ROPE0  = 2'b01;
  localparam logic [1:0]  OWN_ROPE1  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_READ_WAIT, S_WRITE_DONE} state_e;
  typedef enum logic [1:0] {SRC_DRAW, SRC_ROPE0, SRC_ROPE1} src_e;

  state_e                state;
  src_e                  cur_src;
  logic [RD_CNT_W-1:0]   rd_cnt;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic                  rr_ptr;      // 0: rope0 next, 1: rope1 next

  logic                  win_valid;
  src_e                  win_src;
  logic                  win_we;
  logic                  win_lock;
  logic [ADDR_W-1:0]     win_addr;
  logic [DATA_W-1:0]     win_wdata;
  logic [1:0]            win_owner;
  logic                  rope_gnt_now;
  logic                  owner_lock;
  logic                  owner_req;

  // Pick this cycle's winner: draw, then lock owner, then round robin when unlocked
  always_comb begin
    win_valid = 1'b0;
    win_src   = SRC_DRAW;
    if (draw_req) begin
      win_valid = 1'b1;
      win_src   = SRC_DRAW;
    end else if (lock_owner == OWN_ROPE0) begin
      if (rope0_req) begin
        win_valid = 1'b1;
        win_src   = SRC_ROPE0;
      end
    end else if (lock_owner == OWN_ROPE1) begin
      if (rope1_req) begin
        win_valid = 1'b1;
        win_src   = SRC_ROPE1;
      end
    end else if (rope0_req && rope1_req) begin
      win_valid = 1'b1;
      win_src   = rr_ptr ? SRC_ROPE1 : SRC_ROPE0;
    end else if (rope0_req) begin
      win_valid = 1'b1;
      win_src   = SRC_ROPE0;
    end else if (rope1_req) begin
      win_valid = 1'b1;
      win_src   = SRC_ROPE1;
    end
  end

  // Request mux for the winner plus lock-owner views
  always_comb begin
    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_addr  = draw_addr;
    win_wdata = '0;
    case (win_src)
      SRC_ROPE0: begin
        win_we    = rope0_we;
        win_lock  = rope0_lock;
        win_addr  = rope0_addr;
        win_wdata = rope0_wdata;
      end
      SRC_ROPE1: begin
        win_we    = rope1_we;
        win_lock  = rope1_lock;
        win_addr  = rope1_addr;
        win_wdata = rope1_wdata;
      end
      default: ;
    endcase
    win_owner    = (win_src == SRC_ROPE1) ? OWN_ROPE1 : OWN_ROPE0;
    rope_gnt_now = (state == S_IDLE) && win_valid && (win_src != SRC_DRAW);
    owner_lock   = (lock_owner == OWN_ROPE1) ? rope1_lock : rope0_lock;
    owner_req    = (lock_owner == OWN_ROPE1) ? rope1_req  : rope0_req;
  end

  // Transaction FSM, lock tracking and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      cur_src          <= SRC_DRAW;
      rd_cnt           <= '0;
      lock_cnt         <= '0;
      rr_ptr           <= 1'b0;
      draw_gnt         <= 1'b0;
      draw_rvalid      <= 1'b0;
      draw_rdata       <= '0;
      rope0_gnt        <= 1'b0;
      rope0_rvalid     <= 1'b0;
      rope0_rdata      <= '0;
      rope1_gnt        <= 1'b0;
      rope1_rvalid     <= 1'b0;
      rope1_rdata      <= '0;
      ram_addr         <= '0;
      ram_wdata        <= '0;
      ram_wren         <= 1'b0;
      lock_owner       <= OWN_NONE;
      lock_timeout_err <= 1'b0;
    end else begin
      draw_gnt         <= 1'b0;
      rope0_gnt        <= 1'b0;
      rope1_gnt        <= 1'b0;
      draw_rvalid      <= 1'b0;
      rope0_rvalid     <= 1'b0;
      rope1_rvalid     <= 1'b0;
      ram_wren         <= 1'b0;
      lock_timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (win_valid) begin
            cur_src  <= win_src;
            ram_addr <= win_addr;
            rd_cnt   <= '0;
            case (win_src)
              SRC_ROPE0: begin rope0_gnt <= 1'b1; rr_ptr <= 1'b1; end
              SRC_ROPE1: begin rope1_gnt <= 1'b1; rr_ptr <= 1'b0; end
              default:   draw_gnt <= 1'b1;
            endcase
            if (win_we) begin
              ram_wdata <= win_wdata;
              ram_wren  <= 1'b1;
              state     <= S_WRITE_DONE;
            end else begin
              state     <= S_READ_WAIT;
            end
          end
        end
        S_READ_WAIT: begin
          if (rd_cnt == RD_CNT_W'(RD_LAT)) begin
            case (cur_src)
              SRC_ROPE0: begin rope0_rdata <= ram_q; rope0_rvalid <= 1'b1; end
              SRC_ROPE1: begin rope1_rdata <= ram_q; rope1_rvalid <= 1'b1; end
              default:   begin draw_rdata  <= ram_q; draw_rvalid  <= 1'b1; end
            endcase
            state <= S_IDLE;
          end else begin
            rd_cnt <= rd_cnt + RD_CNT_W'(1);
          end
        end
        S_WRITE_DONE: state <= S_IDLE;
        default:      state <= S_IDLE;
      endcase

      // Only the owner (or anyone when unlocked) can win, so a rope grant sets the lock
      if (rope_gnt_now) begin
        lock_cnt   <= '0;
        lock_owner <= win_lock ? win_owner : OWN_NONE;
      end else if (lock_owner != OWN_NONE) begin
        if (!owner_lock && !owner_req) begin
          lock_owner <= OWN_NONE;
        end else if (lock_cnt == LOCK_CNT_W'(LOCK_TIMEOUT)) begin
          lock_owner       <= OWN_NONE;
          lock_timeout_err <= 1'b1;
          rr_ptr           <= (lock_owner == OWN_ROPE0);
        end else begin
          lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_object_ram_arbiter.sv
// Directed bench for object_ram_arbiter with a 2-cycle-latency RAM model.
module tb_object_ram_arbiter;

  localparam int unsigned RD_LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b1;
  logic        draw_req = 1'b0;
  logic [3:0]  draw_addr = '0;
  logic        draw_gnt, draw_rvalid;
  logic [31:0] draw_rdata;
  logic        rope0_req = 1'b0, rope0_we = 1'b0, rope0_lock = 1'b0;
  logic [3:0]  rope0_addr = '0;
  logic [31:0] rope0_wdata = '0;
  logic        rope0_gnt, rope0_rvalid;
  logic [31:0] rope0_rdata;
  logic        rope1_req = 1'b0, rope1_we = 1'b0, rope1_lock = 1'b0;
  logic [3:0]  rope1_addr = '0;
  logic [31:0] rope1_wdata = '0;
  logic        rope1_gnt, rope1_rvalid;
  logic [31:0] rope1_rdata;
  logic [3:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [1:0]  lock_owner;
  logic        lock_timeout_err;

  int checks = 0;
  int failures = 0;

  object_ram_arbiter #(.ADDR_W(4), .DATA_W(32), .RD_LAT(RD_LAT), .LOCK_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_gnt(draw_gnt),
    .draw_rvalid(draw_rvalid), .draw_rdata(draw_rdata),
    .rope0_req(rope0_req), .rope0_we(rope0_we), .rope0_lock(rope0_lock),
    .rope0_addr(rope0_addr), .rope0_wdata(rope0_wdata), .rope0_gnt(rope0_gnt),
    .rope0_rvalid(rope0_rvalid), .rope0_rdata(rope0_rdata),
    .rope1_req(rope1_req), .rope1_we(rope1_we), .rope1_lock(rope1_lock),
    .rope1_addr(rope1_addr), .rope1_wdata(rope1_wdata), .rope1_gnt(rope1_gnt),
    .rope1_rvalid(rope1_rvalid), .rope1_rdata(rope1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
    .lock_owner(lock_owner), .lock_timeout_err(lock_timeout_err)
  );

  always #5 clock = ~clock;

  // RAM model: address sampled, then data registered -> ram_q valid RD_LAT=2 cycles after ram_addr
  logic [31:0] mem [16];
  logic [3:0]  a1;
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 3) ? 32'h1234_5678 : 32'h1000_0000 + 32'(i);
      a1    <= '0;
      ram_q <= '0;
    end else begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      a1    <= ram_addr;
      ram_q <= mem[a1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic gnt_of(input int who);
    case (who)
      0: return draw_gnt;
      1: return rope0_gnt;
      default: return rope1_gnt;
    endcase
  endfunction

  function automatic logic rvalid_of(input int who);
    case (who)
      0: return draw_rvalid;
      1: return rope0_rvalid;
      default: return rope1_rvalid;
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int who);
    case (who)
      0: return draw_rdata;
      1: return rope0_rdata;
      default: return rope1_rdata;
    endcase
  endfunction

  task automatic set_req(input int who, input logic we, input logic lock,
                         input logic [3:0] addr, input logic [31:0] wdata);
    case (who)
      0: begin draw_req = 1'b1; draw_addr = addr; end
      1: begin rope0_req = 1'b1; rope0_we = we; rope0_lock = lock; rope0_addr = addr; rope0_wdata = wdata; end
      default: begin rope1_req = 1'b1; rope1_we = we; rope1_lock = lock; rope1_addr = addr; rope1_wdata = wdata; end
    endcase
  endtask

  task automatic drop_req(input int who);
    case (who)
      0: draw_req = 1'b0;
      1: rope0_req = 1'b0;
      default: rope1_req = 1'b0;
    endcase
  endtask

  // Wait (bounded) for a grant to 'who'; n = negedges waited
  task automatic wait_gnt(input int who, output logic ok, output int n);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 30) begin
      @(negedge clock);
      n++;
      if (gnt_of(who)) ok = 1'b1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_draw_gnt"},    32'(draw_gnt), 32'd0);
    chk({tag, "_rope0_gnt"},   32'(rope0_gnt), 32'd0);
    chk({tag, "_rope1_gnt"},   32'(rope1_gnt), 32'd0);
    chk({tag, "_rvalids"},     32'({draw_rvalid, rope0_rvalid, rope1_rvalid}), 32'd0);
    chk({tag, "_draw_rdata"},  draw_rdata, 32'd0);
    chk({tag, "_rope0_rdata"}, rope0_rdata, 32'd0);
    chk({tag, "_rope1_rdata"}, rope1_rdata, 32'd0);
    chk({tag, "_ram_addr"},    32'(ram_addr), 32'd0);
    chk({tag, "_ram_wdata"},   ram_wdata, 32'd0);
    chk({tag, "_ram_wren"},    32'(ram_wren), 32'd0);
    chk({tag, "_lock_owner"},  32'(lock_owner), 32'd0);
    chk({tag, "_lock_err"},    32'(lock_timeout_err), 32'd0);
  endtask

  typedef struct {
    int          who;        // 0 draw, 1 rope0, 2 rope1
    logic        we;
    logic        lock;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic ok;
    int   n;
    int   order[4];
    int   ng;
    int   err_at, errs, g1_at;
    logic seen;

    vecs[0]  = '{1, 1'b0, 1'b0, 4'd3,  32'h0,         32'h1234_5678, 2'b00};
    vecs[1]  = '{1, 1'b1, 1'b0, 4'd5,  32'hA5A5_A5A5, 32'h0,         2'b00};
    vecs[2]  = '{0, 1'b0, 1'b0, 4'd5,  32'h0,         32'hA5A5_A5A5, 2'b00};
    vecs[3]  = '{2, 1'b1, 1'b0, 4'd7,  32'hDEAD_BEEF, 32'h0,         2'b00};
    vecs[4]  = '{2, 1'b0, 1'b0, 4'd7,  32'h0,         32'hDEAD_BEEF, 2'b00};
    vecs[5]  = '{0, 1'b0, 1'b0, 4'd0,  32'h0,         32'h1000_0000, 2'b00};
    vecs[6]  = '{2, 1'b0, 1'b0, 4'd15, 32'h0,         32'h1000_000F, 2'b00};
    vecs[7]  = '{0, 1'b0, 1'b0, 4'd3,  32'h0,         32'h1234_5678, 2'b00};
    vecs[8]  = '{1, 1'b0, 1'b1, 4'd2,  32'h0,         32'h1000_0002, 2'b01};
    vecs[9]  = '{1, 1'b1, 1'b0, 4'd2,  32'h0BAD_F00D, 32'h0,         2'b00};
    vecs[10] = '{2, 1'b0, 1'b0, 4'd2,  32'h0,         32'h0BAD_F00D, 2'b00};

    repeat (3) @(negedge clock);
    check_reset_state("rst");
    reset   = 1'b0;
    preload = 1'b0;
    @(negedge clock);

    // Table-driven single transactions
    for (int v = 0; v < 11; v++) begin
      logic early;
      set_req(vecs[v].who, vecs[v].we, vecs[v].lock, vecs[v].addr, vecs[v].wdata);
      wait_gnt(vecs[v].who, ok, n);
      chk($sformatf("v%0d_gnt", v), 32'(ok), 32'd1);
      drop_req(vecs[v].who);
      chk($sformatf("v%0d_ram_addr", v), 32'(ram_addr), 32'(vecs[v].addr));
      chk($sformatf("v%0d_wren_at_gnt", v), 32'(ram_wren), 32'(vecs[v].we));
      if (vecs[v].we) begin
        chk($sformatf("v%0d_ram_wdata", v), ram_wdata, vecs[v].wdata);
        @(negedge clock);
        chk($sformatf("v%0d_wren_one_cycle", v), 32'(ram_wren), 32'd0);
      end else begin
        early = 1'b0;
        repeat (RD_LAT) begin
          @(negedge clock);
          if (rvalid_of(vecs[v].who)) early = 1'b1;
        end
        chk($sformatf("v%0d_rvalid_early", v), 32'(early), 32'd0);
        @(negedge clock);
        chk($sformatf("v%0d_rvalid", v), 32'(rvalid_of(vecs[v].who)), 32'd1);
        chk($sformatf("v%0d_rdata", v), rdata_of(vecs[v].who), vecs[v].exp_rdata);
        chk($sformatf("v%0d_rvalid_count", v),
            32'(draw_rvalid) + 32'(rope0_rvalid) + 32'(rope1_rvalid), 32'd1);
        @(negedge clock);
        chk($sformatf("v%0d_rvalid_pulse", v), 32'(rvalid_of(vecs[v].who)), 32'd0);
      end
      chk($sformatf("v%0d_lock_owner", v), 32'(lock_owner), 32'(vecs[v].exp_owner));
    end

    // Three-way contention; draw re-requests once rope0 is granted
    set_req(0, 1'b0, 1'b0, 4'd1, 32'h0);
    set_req(1, 1'b0, 1'b0, 4'd4, 32'h0);
    set_req(2, 1'b0, 1'b0, 4'd6, 32'h0);
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clock);
      if (draw_gnt) begin order[ng] = 0; ng++; drop_req(0); end
      else if (rope0_gnt) begin order[ng] = 1; ng++; drop_req(1); set_req(0, 1'b0, 1'b0, 4'd8, 32'h0); end
      else if (rope1_gnt) begin order[ng] = 2; ng++; drop_req(2); end
    end
    chk("rr_grant_count", 32'(ng), 32'd4);
    chk("rr_order0", 32'(order[0]), 32'd0);
    chk("rr_order1", 32'(order[1]), 32'd1);
    chk("rr_order2", 32'(order[2]), 32'd0);
    chk("rr_order3", 32'(order[3]), 32'd2);
    repeat (5) @(negedge clock);
    chk("rr_draw_rdata",  draw_rdata,  32'h1000_0008);
    chk("rr_rope0_rdata", rope0_rdata, 32'h1000_0004);
    chk("rr_rope1_rdata", rope1_rdata, 32'h1000_0006);

    // Lock hazard: rope1 write to addr 2 is held off until rope0 releases
    set_req(1, 1'b0, 1'b1, 4'd2, 32'h0);
    wait_gnt(1, ok, n);
    chk("lk_rope0_gnt", 32'(ok), 32'd1);
    drop_req(1);
    set_req(2, 1'b1, 1'b0, 4'd2, 32'h2222_2222);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (rope1_gnt) seen = 1'b1;
    end
    chk("lk_rope1_blocked", 32'(seen), 32'd0);
    chk("lk_owner_rope0", 32'(lock_owner), 32'd1);
    chk("lk_rope0_rdata", rope0_rdata, 32'h0BAD_F00D);
    set_req(1, 1'b1, 1'b0, 4'd2, 32'h3333_3333);
    wait_gnt(1, ok, n);
    chk("lk_rope0_wr_gnt", 32'(ok), 32'd1);
    chk("lk_owner_released", 32'(lock_owner), 32'd0);
    drop_req(1);
    wait_gnt(2, ok, n);
    chk("lk_rope1_gnt", 32'(ok), 32'd1);
    chk("lk_rope1_gap", 32'(n), 32'd2);
    drop_req(2);
    repeat (2) @(negedge clock);
    chk("lk_final_mem2", mem[2], 32'h2222_2222);

    // Lock timeout: rope0 holds the lock idle, rope1 waits
    set_req(1, 1'b0, 1'b1, 4'd9, 32'h0);
    wait_gnt(1, ok, n);
    chk("to_rope0_gnt", 32'(ok), 32'd1);
    drop_req(1);
    set_req(2, 1'b0, 1'b0, 4'd9, 32'h0);
    err_at = -1; errs = 0; g1_at = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (lock_timeout_err) begin
        errs++;
        if (err_at < 0) begin
          err_at = i;
          chk("to_owner_cleared", 32'(lock_owner), 32'd0);
        end
      end
      if (rope1_gnt && g1_at < 0) begin
        g1_at = i;
        drop_req(2);
      end
    end
    chk("to_err_cycle", 32'(err_at), 32'd17);
    chk("to_err_pulses", 32'(errs), 32'd1);
    chk("to_rope1_gnt_cycle", 32'(g1_at), 32'd18);
    chk("to_rope1_rdata", rope1_rdata, 32'h1000_0009);
    rope0_lock = 1'b0;

    // Reset during S_READ_WAIT aborts the read
    set_req(1, 1'b0, 1'b0, 4'd3, 32'h0);
    wait_gnt(1, ok, n);
    chk("rs_gnt", 32'(ok), 32'd1);
    drop_req(1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("rs");
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (draw_rvalid || rope0_rvalid || rope1_rvalid) seen = 1'b1;
    end
    chk("rs_no_rvalid", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
